// File: rtl/mips32_pkg.sv
// mips32_pkg: run-controller state encoding and mips32 core constants
package mips32_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, DUMP_RD, DUMP_OUT, FIN} run_state_e;
    localparam int NUM_REGS = 32;
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int WORD_W = 32;
    localparam logic [5:0] HLT_OPCODE = 6'b111111;
    localparam logic [WORD_W-1:0] NOP_OR_DUMMY = 32'h0e94a000;
endpackage

// File: rtl/mips32_run_ctrl_if.sv
// mips32_run_ctrl_if: program-in stream, memory write port and dump-out stream of the run controller
interface mips32_run_ctrl_if
    import mips32_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic in_valid;
    logic in_ready;
    logic [WORD_W-1:0] in_data;
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic out_valid;
    logic out_ready;
    logic [REG_AW-1:0] out_idx;
    logic [WORD_W-1:0] out_data;
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, out_valid, out_idx, out_data
    );
    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/mips32_dump_streamer.sv
// mips32_dump_streamer: reads R0..R(NUM_DUMP-1) through the register port and streams them out
module mips32_dump_streamer
    import mips32_pkg::*;
#(
    parameter int NUM_DUMP = 8
) (
    input  logic clk1,
    input  logic rst_n,
    input  run_state_e st,
    input  logic abort,
    input  logic out_ready,
    input  logic [WORD_W-1:0] reg_rdata,
    output logic [REG_AW-1:0] reg_raddr,
    output logic out_valid,
    output logic [REG_AW-1:0] out_idx,
    output logic [WORD_W-1:0] out_data,
    output logic captured,
    output logic last
);
    logic [REG_AW:0] idx;
    logic rd_wait;
    assign captured = st == DUMP_RD && rd_wait;
    assign last = idx == (REG_AW+1)'(NUM_DUMP - 1);
    // rd_wait marks the second DUMP_RD cycle, when reg_rdata reflects reg_raddr
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            idx <= '0;
            rd_wait <= 1'b0;
            reg_raddr <= '0;
            out_valid <= 1'b0;
            out_idx <= '0;
            out_data <= '0;
        end else if (abort || (st != DUMP_RD && st != DUMP_OUT)) begin
            idx <= '0;
            rd_wait <= 1'b0;
            reg_raddr <= '0;
            out_valid <= 1'b0;
        end else if (st == DUMP_RD) begin
            rd_wait <= !rd_wait;
            if (rd_wait) begin
                out_valid <= 1'b1;
                out_idx <= idx[REG_AW-1:0];
                out_data <= reg_rdata;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            idx <= idx + (REG_AW+1)'(1);
            reg_raddr <= REG_AW'(idx + (REG_AW+1)'(1));
        end
    end
endmodule

// File: rtl/mips32_run_ctrl.sv
// mips32_run_ctrl: host-side load/run/dump sequencer for the mips32 core.
// Define MIPS32_RUN_CYCLE_COUNT_EN to add run_cycles, the RUN cycle count latched when RUN ends.
module mips32_run_ctrl
    import mips32_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NUM_DUMP = 8,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W = 16
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic [ADDR_W:0] prog_len,
    mips32_run_ctrl_if.master bus,
    output logic cpu_init,
    output logic cpu_run,
    input  logic cpu_halted,
    output logic [REG_AW-1:0] reg_raddr,
    input  logic [WORD_W-1:0] reg_rdata,
    output logic busy,
    output logic done,
    output logic err
`ifdef MIPS32_RUN_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] run_cycles
`endif
);
    run_state_e st;
    logic [ADDR_W:0] len, cnt, len_c;
    logic [CNT_W-1:0] cyc;
    logic captured, last, stop;
    assign len_c = prog_len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : prog_len;
    assign stop = cpu_halted || cyc == CNT_W'(TIMEOUT - 1);
    assign busy = st != IDLE;
    mips32_dump_streamer #(.NUM_DUMP(NUM_DUMP)) u_dump (
        .clk1(clk1),
        .rst_n(rst_n),
        .st(st),
        .abort(abort),
        .out_ready(bus.out_ready),
        .reg_rdata(reg_rdata),
        .reg_raddr(reg_raddr),
        .out_valid(bus.out_valid),
        .out_idx(bus.out_idx),
        .out_data(bus.out_data),
        .captured(captured),
        .last(last)
    );
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            st <= IDLE;
            len <= '0;
            cnt <= '0;
            cyc <= '0;
            bus.in_ready <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
            cpu_init <= 1'b0;
            cpu_run <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
`ifdef MIPS32_RUN_CYCLE_COUNT_EN
            run_cycles <= '0;
`endif
        end else if (abort) begin
            st <= IDLE;
            bus.in_ready <= 1'b0;
            bus.mem_we <= 1'b0;
            cpu_init <= 1'b0;
            cpu_run <= 1'b0;
            done <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            cpu_init <= 1'b0;
            done <= 1'b0;
            case (st)
                IDLE: if (start) begin
                    err <= 1'b0;
                    len <= len_c;
                    cnt <= '0;
                    st <= len_c == '0 ? INIT : LOAD;
                    bus.in_ready <= len_c != '0;
                    cpu_init <= len_c == '0;
`ifdef MIPS32_RUN_CYCLE_COUNT_EN
                    run_cycles <= '0;
`endif
                end
                LOAD: if (bus.in_valid) begin
                    bus.mem_we <= 1'b1;
                    bus.mem_addr <= cnt[ADDR_W-1:0];
                    bus.mem_wdata <= bus.in_data;
                    cnt <= cnt + (ADDR_W+1)'(1);
                    if (cnt + (ADDR_W+1)'(1) == len) begin
                        st <= INIT;
                        bus.in_ready <= 1'b0;
                        cpu_init <= 1'b1;
                    end
                end
                INIT: begin
                    cyc <= '0;
                    cpu_run <= 1'b1;
                    st <= RUN;
                end
                RUN: begin
                    cyc <= cyc + CNT_W'(1);
                    // a halt seen on the timeout cycle still counts as normal completion
                    if (stop) begin
                        err <= !cpu_halted;
                        cpu_run <= 1'b0;
                        st <= DUMP_RD;
`ifdef MIPS32_RUN_CYCLE_COUNT_EN
                        run_cycles <= cyc + CNT_W'(1);
`endif
                    end
                end
                DUMP_RD: if (captured) st <= DUMP_OUT;
                DUMP_OUT: if (bus.out_valid && bus.out_ready) begin
                    st <= last ? FIN : DUMP_RD;
                    done <= last;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips32_run_ctrl.sv
// tb_mips32_run_ctrl: directed load/run/dump scenarios against a small behavioural mips32 core
module tb_mips32_run_ctrl;
    import mips32_pkg::*;
    localparam int AW = 10;
    localparam int ND = 8;
    localparam int TO = 64;
    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [AW:0] prog_len = '0;
    logic cpu_init, cpu_run, busy, done, err, halted;
    logic [4:0] reg_raddr;
    logic [31:0] reg_rdata;
    int compared = 0;
    int mismatched = 0;
    mips32_run_ctrl_if #(.ADDR_W(AW)) bus();
    mips32_run_ctrl #(.ADDR_W(AW), .NUM_DUMP(ND), .TIMEOUT(TO), .CNT_W(16)) dut (
        .clk1(clk1),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .prog_len(prog_len),
        .bus(bus),
        .cpu_init(cpu_init),
        .cpu_run(cpu_run),
        .cpu_halted(halted),
        .reg_raddr(reg_raddr),
        .reg_rdata(reg_rdata),
        .busy(busy),
        .done(done),
        .err(err)
    );
    always #5 clk1 = ~clk1;
    // behavioural core: one instruction per cpu_run cycle, synchronous register read port
    logic [31:0] imem [0:1023];
    logic [31:0] regs [0:31];
    logic [9:0] pc;
    logic [31:0] ir, ra, rb, imm;
    always @(posedge clk1) begin
        if (bus.mem_we) imem[bus.mem_addr] <= bus.mem_wdata;
        reg_rdata <= regs[reg_raddr];
        if (!rst_n) begin
            pc <= '0;
            halted <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (cpu_init) begin
            pc <= '0;
            halted <= 1'b0;
        end else if (cpu_run && !halted) begin
            ir = imem[pc];
            ra = regs[ir[25:21]];
            rb = regs[ir[20:16]];
            imm = {{16{ir[15]}}, ir[15:0]};
            case (ir[31:26])
                6'b000000: if (ir[15:11] != 0) regs[ir[15:11]] <= ra + rb;
                6'b000001: if (ir[15:11] != 0) regs[ir[15:11]] <= ra - rb;
                6'b000011: if (ir[15:11] != 0) regs[ir[15:11]] <= ra | rb;
                6'b000101: if (ir[15:11] != 0) regs[ir[15:11]] <= ra * rb;
                6'b001010: if (ir[20:16] != 0) regs[ir[20:16]] <= ra + imm;
                6'b001011: if (ir[20:16] != 0) regs[ir[20:16]] <= ra - imm;
                6'b001111: if (ir[20:16] != 0) regs[ir[20:16]] <= ra * imm;
                HLT_OPCODE: halted <= 1'b1;
                default: ;
            endcase
            pc <= pc + 10'd1;
        end
    end
    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int im);
        return {op, 5'(rs), 5'(rt), 16'(im)};
    endfunction
    logic [31:0] prog [0:63];
    logic [31:0] exp_a [0:7] = '{32'd0, 32'd20, 32'd30, 32'd50, 32'd35, 32'd15, 32'd525, 32'd1500};
    int wr_addr[$];
    logic [31:0] wr_data[$];
    int d_idx[$];
    logic [31:0] d_data[$];
    int n_init, n_run, n_done, stall_cnt, stall_bad, abort_c, end_c;
    task automatic load_arith();
        prog[0] = enc_i(6'b001010, 1, 0, 20);
        prog[1] = enc_i(6'b001010, 2, 0, 30);
        prog[2] = NOP_OR_DUMMY;
        prog[3] = enc_r(6'b000000, 3, 1, 2);
        prog[4] = enc_i(6'b001011, 4, 3, 15);
        prog[5] = NOP_OR_DUMMY;
        prog[6] = enc_r(6'b000001, 5, 3, 4);
        prog[7] = enc_i(6'b001111, 6, 5, 35);
        prog[8] = enc_r(6'b000101, 7, 3, 2);
        prog[9] = NOP_OR_DUMMY;
        prog[10] = {HLT_OPCODE, 26'd0};
        prog[11] = NOP_OR_DUMMY;
    endtask
    task automatic drive_job(input int len, input int gap_pct, input int stall_idx, input int abort_at, input int restart_at);
        int wp;
        bit pst;
        logic [4:0] pidx;
        logic [31:0] pdat;
        wr_addr.delete();
        wr_data.delete();
        d_idx.delete();
        d_data.delete();
        n_init = 0; n_run = 0; n_done = 0; stall_cnt = 0; stall_bad = 0;
        abort_c = -1; end_c = -1; wp = 0; pst = 0; pidx = '0; pdat = '0;
        @(negedge clk1);
        start = 1'b1;
        prog_len = (AW+1)'(len);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk1);
            start = c == restart_at;
            abort = 1'b0;
            if (bus.mem_we) begin
                wr_addr.push_back(int'(bus.mem_addr));
                wr_data.push_back(bus.mem_wdata);
            end
            if (cpu_init) n_init++;
            if (cpu_run) n_run++;
            if (done) n_done++;
            if (pst && (bus.out_idx !== pidx || bus.out_data !== pdat)) stall_bad++;
            if (!busy) begin
                end_c = c;
                break;
            end
            if (abort_at >= 0 && wp == abort_at && bus.in_ready && abort_c < 0) begin
                abort = 1'b1;
                abort_c = c;
            end
            bus.in_valid = wp < len && $urandom_range(0, 99) >= gap_pct;
            bus.in_data = bus.in_valid ? prog[wp] : 32'hdeadbeef;
            if (bus.in_valid && bus.in_ready && !abort) wp++;
            bus.out_ready = !(bus.out_valid && int'(bus.out_idx) == stall_idx && stall_cnt < 5);
            if (!bus.out_ready) stall_cnt++;
            if (bus.out_valid && bus.out_ready && !abort) begin
                d_idx.push_back(int'(bus.out_idx));
                d_data.push_back(bus.out_data);
            end
            pst = bus.out_valid && !bus.out_ready;
            pidx = bus.out_idx;
            pdat = bus.out_data;
        end
        start = 1'b0;
        abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk1);
        compared++;
        if ({bus.in_ready, bus.mem_we, bus.out_valid, cpu_init, cpu_run, busy, done, err} !== 8'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 00000000", {bus.in_ready, bus.mem_we, bus.out_valid, cpu_init, cpu_run, busy, done, err});
        end
        compared++;
        if ({bus.mem_addr, bus.mem_wdata, reg_raddr, bus.out_idx, bus.out_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_buses: got %h want 0", {bus.mem_addr, bus.mem_wdata, reg_raddr, bus.out_idx, bus.out_data});
        end
        rst_n = 1'b1;
        @(negedge clk1);
    endtask
    task automatic test_arith();
        load_arith();
        drive_job(12, 0, -1, -1, -1);
        compared++;
        if (end_c < 0) begin mismatched++; $display("FAIL arith_end: job did not finish within budget"); end
        compared++;
        if (wr_addr.size() !== 12) begin mismatched++; $display("FAIL arith_writes: got %0d want 12", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 12; i++) begin
            compared++;
            if (wr_addr[i] !== i || wr_data[i] !== prog[i]) begin
                mismatched++;
                $display("FAIL arith_wr[%0d]: got @%0d=%h want @%0d=%h", i, wr_addr[i], wr_data[i], i, prog[i]);
            end
        end
        compared++;
        if (d_data.size() !== 8) begin mismatched++; $display("FAIL arith_dump_cnt: got %0d want 8", d_data.size()); end
        for (int i = 0; i < d_data.size() && i < 8; i++) begin
            compared++;
            if (d_idx[i] !== i || d_data[i] !== exp_a[i]) begin
                mismatched++;
                $display("FAIL arith_dump[%0d]: got R%0d=%0d want R%0d=%0d", i, d_idx[i], d_data[i], i, exp_a[i]);
            end
        end
        compared++;
        if (n_done !== 1 || n_init !== 1 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL arith_status: got done=%0d init=%0d err=%b want 1 1 0", n_done, n_init, err);
        end
    endtask
    task automatic test_timeout();
        for (int i = 0; i < 64; i++) prog[i] = enc_i(6'b001010, 1, 1, 1);
        drive_job(64, 0, -1, -1, -1);
        compared++;
        if (wr_addr.size() !== 64) begin mismatched++; $display("FAIL to_writes: got %0d want 64", wr_addr.size()); end
        compared++;
        if (n_run !== 64) begin mismatched++; $display("FAIL to_run_cycles: got %0d want 64", n_run); end
        compared++;
        if (err !== 1'b1) begin mismatched++; $display("FAIL to_err: got %b want 1", err); end
        compared++;
        if (d_data.size() !== 8 || n_done !== 1) begin
            mismatched++;
            $display("FAIL to_dump: got words=%0d done=%0d want 8 1", d_data.size(), n_done);
        end
        for (int i = 0; i < d_data.size() && i < 8; i++) begin
            compared++;
            if (d_data[i] !== (i == 1 ? 32'd84 : exp_a[i])) begin
                mismatched++;
                $display("FAIL to_dump[%0d]: got %0d want %0d", i, d_data[i], i == 1 ? 32'd84 : exp_a[i]);
            end
        end
    endtask
    task automatic test_stall();
        load_arith();
        drive_job(12, 30, 3, -1, -1);
        compared++;
        if (wr_addr.size() !== 12) begin mismatched++; $display("FAIL stall_writes: got %0d want 12", wr_addr.size()); end
        for (int i = 0; i < wr_addr.size() && i < 12; i++) begin
            compared++;
            if (wr_addr[i] !== i || wr_data[i] !== prog[i]) begin
                mismatched++;
                $display("FAIL stall_wr[%0d]: got @%0d=%h want @%0d=%h", i, wr_addr[i], wr_data[i], i, prog[i]);
            end
        end
        compared++;
        if (d_data.size() !== 8) begin mismatched++; $display("FAIL stall_dump_cnt: got %0d want 8", d_data.size()); end
        for (int i = 0; i < d_data.size() && i < 8; i++) begin
            compared++;
            if (d_idx[i] !== i || d_data[i] !== exp_a[i]) begin
                mismatched++;
                $display("FAIL stall_dump[%0d]: got R%0d=%0d want R%0d=%0d", i, d_idx[i], d_data[i], i, exp_a[i]);
            end
        end
        compared++;
        if (stall_cnt !== 5 || stall_bad !== 0) begin
            mismatched++;
            $display("FAIL stall_hold: got stalls=%0d unstable=%0d want 5 0", stall_cnt, stall_bad);
        end
        compared++;
        if (err !== 1'b0 || n_done !== 1) begin mismatched++; $display("FAIL stall_status: got err=%b done=%0d want 0 1", err, n_done); end
    endtask
    task automatic test_abort();
        load_arith();
        drive_job(12, 0, -1, 3, -1);
        compared++;
        if (wr_addr.size() !== 3) begin mismatched++; $display("FAIL abort_writes: got %0d want 3", wr_addr.size()); end
        compared++;
        if (abort_c < 0 || end_c - abort_c !== 1) begin
            mismatched++;
            $display("FAIL abort_idle: got abort@%0d idle@%0d want idle one cycle later", abort_c, end_c);
        end
        compared++;
        if (n_init !== 0 || n_done !== 0 || d_data.size() !== 0) begin
            mismatched++;
            $display("FAIL abort_quiet: got init=%0d done=%0d words=%0d want 0 0 0", n_init, n_done, d_data.size());
        end
        drive_job(12, 0, -1, -1, -1);
        compared++;
        if (wr_addr.size() !== 12 || wr_addr[0] !== 0 || n_done !== 1) begin
            mismatched++;
            $display("FAIL abort_reload: got writes=%0d first=%0d done=%0d want 12 0 1", wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : -1, n_done);
        end
    endtask
    task automatic test_busy_start();
        load_arith();
        drive_job(12, 0, -1, -1, 20);
        compared++;
        if (wr_addr.size() !== 12 || n_init !== 1 || n_done !== 1 || d_data.size() !== 8) begin
            mismatched++;
            $display("FAIL busy_start: got writes=%0d init=%0d done=%0d words=%0d want 12 1 1 8", wr_addr.size(), n_init, n_done, d_data.size());
        end
    endtask
    task automatic test_zero_len();
        prog[0] = {HLT_OPCODE, 26'd0};
        drive_job(1, 0, -1, -1, -1);
        drive_job(0, 0, -1, -1, -1);
        compared++;
        if (wr_addr.size() !== 0) begin mismatched++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
        compared++;
        if (n_init !== 1 || n_run !== 2) begin mismatched++; $display("FAIL zero_run: got init=%0d run=%0d want 1 2", n_init, n_run); end
        compared++;
        if (d_data.size() !== 8 || n_done !== 1 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_dump: got words=%0d done=%0d err=%b want 8 1 0", d_data.size(), n_done, err);
        end
        compared++;
        if (d_data.size() == 8 && d_data[7] !== 32'd1500) begin mismatched++; $display("FAIL zero_r7: got %0d want 1500", d_data[7]); end
    endtask
    task automatic test_reset_run();
        bit seen;
        seen = 0;
        @(negedge clk1);
        start = 1'b1;
        prog_len = '0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk1);
            start = 1'b0;
            seen = cpu_run;
        end
        compared++;
        if (!seen) begin mismatched++; $display("FAIL rst_run_reach: got no cpu_run want cpu_run within 20 cycles"); end
        rst_n = 1'b0;
        @(negedge clk1);
        compared++;
        if ({bus.in_ready, bus.mem_we, bus.out_valid, cpu_init, cpu_run, busy, done, err} !== 8'b0) begin
            mismatched++;
            $display("FAIL rst_run_flags: got %b want 00000000", {bus.in_ready, bus.mem_we, bus.out_valid, cpu_init, cpu_run, busy, done, err});
        end
        compared++;
        if ({bus.mem_addr, bus.mem_wdata, reg_raddr, bus.out_idx, bus.out_data} !== '0) begin
            mismatched++;
            $display("FAIL rst_run_buses: got %h want 0", {bus.mem_addr, bus.mem_wdata, reg_raddr, bus.out_idx, bus.out_data});
        end
        rst_n = 1'b1;
        @(negedge clk1);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_arith();
        test_timeout();
        test_stall();
        test_abort();
        test_busy_start();
        test_zero_len();
        test_reset_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
